// File: rtl/inst_queue.sv
// inst_queue: in-order decoded-instruction FIFO between decode and dispatch, flushed on squash.
// Optional IQ_BYPASS_EN: an empty queue forwards in_pack_i straight to out_pack_o in the same cycle.
package iq_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fu;
        logic        imm_valid;
    } DECODED_PACK;
endpackage

module inst_queue
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AFULL_TH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     squash_i,
    input  logic                     in_valid_i,
    input  DECODED_PACK              in_pack_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    output DECODED_PACK              out_pack_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     almost_full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, free;
    DECODED_PACK   mem_q [DEPTH];
    logic          empty, full, bypass, enq, deq;

    always_comb begin
        empty  = head_q == tail_q;
        full   = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
`ifdef IQ_BYPASS_EN
        bypass = empty && in_valid_i && !squash_i;
`else
        bypass = 1'b0;
`endif
        deq    = !empty && out_ready_i && !squash_i;
        // A bypassed entry that is consumed immediately never touches storage.
        enq    = in_valid_i && !full && !squash_i && !(bypass && out_ready_i);
        head_d = (reset || squash_i) ? '0 : head_q + PW'(deq);
        tail_d = (reset || squash_i) ? '0 : tail_q + PW'(enq);
    end

    assign in_ready_o    = !full;
    assign out_valid_o   = !empty || bypass;
    assign out_pack_o    = !empty ? mem_q[head_q[AW-1:0]] : bypass ? in_pack_i : '0;
    assign count_o       = tail_q - head_q;
    assign free          = PW'(DEPTH) - count_o;
    assign almost_full_o = 32'(free) <= AFULL_TH;

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
        if (enq) mem_q[tail_q[AW-1:0]] <= in_pack_i;
    end
endmodule
